nes_cpu_bus_responder: RTL and testbench
========================================

# nes_cpu_bus_responder

Responder end of the NES CPU bus: decodes every access issued by the CPU core (address, write data, active-low read/write) and answers it. Holds the 2 KiB internal work RAM (mirrored), serialises the two controller ports at $4016/$4017, and forwards PPU-register and cartridge accesses over req/ack handshakes. It stalls the CPU through a ready line when a forwarded access is outstanding. It sits between the CPU core and the PPU/cartridge blocks.

## Interface
- TIMEOUT_CYCLES, 16: max cycles to wait for a peripheral ack before completing with open-bus data (range 2..255).
- clk  in  1  system clock, all logic on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- address_input  in  16  CPU address.
- data_input  in  8  CPU write data.
- nrw_input  in  1  1 = read, 0 = write (active-low write).
- data_output  out  8  read data to CPU.
- rdy_output  out  1  1 = access completes this cycle; 0 = CPU must hold address, data and nrw.
- ppu_req / ppu_ack  out / in  1 / 1  PPU register handshake.
- ppu_addr  out  3  register index (address_input[2:0]).
- ppu_wdata / ppu_rdata  out / in  8 / 8  PPU data.
- ppu_nrw  out  1  copy of nrw_input.
- cart_req / cart_ack  out / in  1 / 1  cartridge handshake.
- cart_addr  out  16  full CPU address.
- cart_wdata / cart_rdata  out / in  8 / 8  cartridge data.
- cart_nrw  out  1  copy of nrw_input.
- joy1_buttons, joy2_buttons  in  8 / 8  parallel button state, bit0 = A … bit7 = Right, 1 = pressed.

## Operation
- Decode: $0000-$1FFF RAM, index address[10:0] (4× mirror); $2000-$3FFF PPU, index address[2:0] (mirrored every 8); $4016 controller 1 / strobe; $4017 controller 2 read (writes ignored); $4000-$4015 and $4018-$401F unmapped; $4020-$FFFF cartridge.
- Open-bus register ob: loaded with every completed transfer's data (write data or read data). Unmapped reads return ob; unmapped writes update ob only.
- Writes also load data_output with the write data.
- RAM: synchronous 2048×8. Read returns stored byte. Write stores data_input.
- Controller: write $4016 sets strobe = data_input[0]. While strobe = 1, shift1/shift2 reload from joy1/joy2 every cycle. Read $4016 returns {ob[7:5], 4'b0000, shift1[0]}; $4017 likewise with shift2. A read with strobe = 0 then shifts right, filling bit7 with 1, so reads 9+ return 1. A read with strobe = 1 returns the current joy bit0 and does not shift.
- FSM states IDLE, WAIT_PPU, WAIT_CART.
  - IDLE: RAM, controller and unmapped accesses complete at the capture edge.
  - PPU access: go to WAIT_PPU; ppu_req = 1, rdy_output = 0.
  - Cartridge access: go to WAIT_CART; cart_req = 1, rdy_output = 0.
- WAIT_x: each edge, if ack = 1, complete the access:
  - read: data_output = rdata, ob = rdata; write: ob = wdata.
  - Deassert req, rdy_output = 1, return to IDLE.
- Timeout: if the wait counter reaches TIMEOUT_CYCLES with no ack, complete anyway. A read returns ob; a write is dropped. Same exit as an ack.
- Request fields (addr, wdata, nrw) are registered at the capture edge and held stable while req = 1.

## Timing
- Capture edge: the rising edge ending the cycle in which the CPU presents an access with rdy_output = 1.
- RAM, controller and unmapped accesses: data_output valid from the capture edge, throughout the next cycle. rdy_output stays 1, so back-to-back accesses sustain 1 per cycle.
- Forwarded accesses:
  - req and rdy_output = 0 rise and fall at the capture edge.
  - An ack sampled at edge k gives data_output, req = 0 and rdy_output = 1 after edge k.
  - Minimum stall is 1 cycle (ack already high at the first edge after the capture edge).
  - Ack must be sampled while req = 1; an ack seen in IDLE is ignored.
- Wait counter clears at the capture edge and increments each WAIT edge. Timeout completes at edge TIMEOUT_CYCLES after the capture edge.
- Reset values: data_output 0, rdy_output 1, ppu_req 0, cart_req 0, ppu_addr / ppu_wdata / cart_addr / cart_wdata 0, ppu_nrw / cart_nrw 1, ob 0, strobe 0, shift regs 0, state IDLE. RAM contents are undefined.
- Reset mid-wait: req drops and rdy_output rises immediately (asynchronous); the outstanding access is abandoned.
- While rdy_output = 0, CPU inputs are ignored.

## Test plan
- RAM mirror: write $0005 ← $A5, then read $1805 → data_output $A5 one cycle later, rdy_output high throughout.
- Controller: joy1 = $81; write $4016 ← 1 then ← 0; nine reads of $4016 → bit0 sequence 1,0,0,0,0,0,0,1,1 and bits[4:1] = 0.
- PPU read: read $3FFA; ppu_addr = 2, ppu_req high, rdy_output low; ack after 3 cycles with ppu_rdata $5C → data_output $5C, rdy_output high the same edge.
- Cartridge timeout: read $8000 with cart_ack tied low; after a prior read of $33, data_output = $33 and rdy_output rises 16 edges after capture.
- Open bus: write $4005 ← $E7, then read $4019 → $E7; read $4017 → upper bits [7:5] = 3'b111.
- Reset mid-wait: nrst low during WAIT_CART → cart_req 0, rdy_output 1 without waiting for a clock edge; after release, a RAM read completes normally.

Source files
------------

// File: rtl/nes_cpu_bus_responder.sv
// nes_cpu_bus_responder: NES CPU bus slave with 2 KiB mirrored RAM, the
// $4016/$4017 pads, open bus, and PPU/cart req/ack forwarding with stall.
module nes_cpu_bus_responder #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [15:0] address_input,
  input  logic [7:0]  data_input,
  input  logic        nrw_input,
  output logic [7:0]  data_output,
  output logic        rdy_output,
  output logic        ppu_req,
  input  logic        ppu_ack,
  output logic [2:0]  ppu_addr,
  output logic [7:0]  ppu_wdata,
  input  logic [7:0]  ppu_rdata,
  output logic        ppu_nrw,
  output logic        cart_req,
  input  logic        cart_ack,
  output logic [15:0] cart_addr,
  output logic [7:0]  cart_wdata,
  input  logic [7:0]  cart_rdata,
  output logic        cart_nrw,
  input  logic [7:0]  joy1_buttons,
  input  logic [7:0]  joy2_buttons
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PPU,
    WAIT_CART
  } state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT_CYCLES - 1);

  state_t state, state_d;

  logic [7:0] mem [0:2047];
  logic [7:0] ob;
  logic [7:0] shift1;
  logic [7:0] shift2;
  logic [7:0] cnt;
  logic       strobe;

  logic is_ram, is_ppu, is_io;
  logic is_joy1, is_joy2, is_open, is_cart;

  assign is_ram  = address_input[15:13] == 3'b000;
  assign is_ppu  = address_input[15:13] == 3'b001;
  assign is_io   = address_input[15:5] == 11'h200;
  assign is_joy1 = address_input == 16'h4016;
  assign is_joy2 = address_input == 16'h4017;
  assign is_open = is_io && !is_joy1 && !is_joy2;
  assign is_cart = !(is_ram || is_ppu || is_io);

  logic [10:0] ram_idx;
  logic [7:0]  ram_rd;
  logic [7:0]  joy1_rd;
  logic [7:0]  joy2_rd;

  assign ram_idx = address_input[10:0];
  assign ram_rd  = mem[ram_idx];

  // With strobe high the pads are transparent: report live A button.
  assign joy1_rd = {ob[7:5], 4'b0000,
                    strobe ? joy1_buttons[0] : shift1[0]};
  assign joy2_rd = {ob[7:5], 4'b0000,
                    strobe ? joy2_buttons[0] : shift2[0]};

  logic       tmo;
  logic       fwd_ack;
  logic [7:0] fwd_rdata;
  logic [7:0] fwd_wdata;
  logic       fwd_nrw;

  assign tmo = cnt == TMAX;
  assign fwd_ack = (state == WAIT_PPU && ppu_ack) ||
                   (state == WAIT_CART && cart_ack);
  assign fwd_rdata = (state == WAIT_PPU) ? ppu_rdata : cart_rdata;
  assign fwd_wdata = (state == WAIT_PPU) ? ppu_wdata : cart_wdata;
  assign fwd_nrw   = (state == WAIT_PPU) ? ppu_nrw : cart_nrw;

  assign rdy_output = state == IDLE;
  assign ppu_req    = state == WAIT_PPU;
  assign cart_req   = state == WAIT_CART;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (is_ppu)
          state_d = WAIT_PPU;
        else if (is_cart)
          state_d = WAIT_CART;
      end
      WAIT_PPU: begin
        if (ppu_ack || tmo)
          state_d = IDLE;
      end
      WAIT_CART: begin
        if (cart_ack || tmo)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && is_ram && !nrw_input)
      mem[ram_idx] <= data_input;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      data_output <= 8'h00;
      ob          <= 8'h00;
      strobe      <= 1'b0;
      shift1      <= 8'h00;
      shift2      <= 8'h00;
      cnt         <= 8'h00;
      ppu_addr    <= 3'd0;
      ppu_wdata   <= 8'h00;
      ppu_nrw     <= 1'b1;
      cart_addr   <= 16'h0000;
      cart_wdata  <= 8'h00;
      cart_nrw    <= 1'b1;
    end else begin
      state <= state_d;
      if (strobe) begin
        shift1 <= joy1_buttons;
        shift2 <= joy2_buttons;
      end
      if (state == IDLE) begin
        cnt <= 8'h00;
        unique case (1'b1)
          is_ram: begin
            data_output <= nrw_input ? ram_rd : data_input;
            ob          <= nrw_input ? ram_rd : data_input;
          end
          is_ppu: begin
            ppu_addr  <= address_input[2:0];
            ppu_wdata <= data_input;
            ppu_nrw   <= nrw_input;
          end
          is_cart: begin
            cart_addr  <= address_input;
            cart_wdata <= data_input;
            cart_nrw   <= nrw_input;
          end
          is_joy1: begin
            if (nrw_input) begin
              data_output <= joy1_rd;
              ob          <= joy1_rd;
              if (!strobe)
                shift1 <= {1'b1, shift1[7:1]};
            end else begin
              strobe      <= data_input[0];
              data_output <= data_input;
              ob          <= data_input;
            end
          end
          is_joy2: begin
            if (nrw_input) begin
              data_output <= joy2_rd;
              ob          <= joy2_rd;
              if (!strobe)
                shift2 <= {1'b1, shift2[7:1]};
            end else begin
              data_output <= data_input;
              ob          <= data_input;
            end
          end
          is_open: begin
            data_output <= nrw_input ? ob : data_input;
            if (!nrw_input)
              ob <= data_input;
          end
          default: ;
        endcase
      end else begin
        cnt <= cnt + 8'd1;
        if (fwd_ack) begin
          data_output <= fwd_nrw ? fwd_rdata : fwd_wdata;
          ob          <= fwd_nrw ? fwd_rdata : fwd_wdata;
        end else if (tmo && fwd_nrw) begin
          data_output <= ob;
        end
      end
    end
  end

endmodule

// File: tb/tb_nes_cpu_bus_responder.sv
// tb_nes_cpu_bus_responder: directed vectors plus hand-written sequences
// for controller shifting, PPU/cart handshakes, timeout and async reset.
module tb_nes_cpu_bus_responder;

  logic        clk;
  logic        nrst;
  logic [15:0] address_input;
  logic [7:0]  data_input;
  logic        nrw_input;
  logic [7:0]  data_output;
  logic        rdy_output;
  logic        ppu_req;
  logic        ppu_ack;
  logic [2:0]  ppu_addr;
  logic [7:0]  ppu_wdata;
  logic [7:0]  ppu_rdata;
  logic        ppu_nrw;
  logic        cart_req;
  logic        cart_ack;
  logic [15:0] cart_addr;
  logic [7:0]  cart_wdata;
  logic [7:0]  cart_rdata;
  logic        cart_nrw;
  logic [7:0]  joy1_buttons;
  logic [7:0]  joy2_buttons;

  nes_cpu_bus_responder #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .nrst(nrst),
    .address_input(address_input),
    .data_input(data_input),
    .nrw_input(nrw_input),
    .data_output(data_output),
    .rdy_output(rdy_output),
    .ppu_req(ppu_req),
    .ppu_ack(ppu_ack),
    .ppu_addr(ppu_addr),
    .ppu_wdata(ppu_wdata),
    .ppu_rdata(ppu_rdata),
    .ppu_nrw(ppu_nrw),
    .cart_req(cart_req),
    .cart_ack(cart_ack),
    .cart_addr(cart_addr),
    .cart_wdata(cart_wdata),
    .cart_rdata(cart_rdata),
    .cart_nrw(cart_nrw),
    .joy1_buttons(joy1_buttons),
    .joy2_buttons(joy2_buttons)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [15:0] a,
                     input logic [7:0] d,
                     input logic nrw);
    address_input = a;
    data_input    = d;
    nrw_input     = nrw;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        nrw;
    logic [7:0]  exp;
  } vec_t;

  vec_t tv [10];

  initial begin
    tv[0] = '{16'h0005, 8'hA5, 1'b0, 8'hA5};
    tv[1] = '{16'h1805, 8'h00, 1'b1, 8'hA5};
    tv[2] = '{16'h07FF, 8'h3C, 1'b0, 8'h3C};
    tv[3] = '{16'h0FFF, 8'h00, 1'b1, 8'h3C};
    tv[4] = '{16'h0005, 8'h00, 1'b1, 8'hA5};
    tv[5] = '{16'h4005, 8'hE7, 1'b0, 8'hE7};
    tv[6] = '{16'h4019, 8'h00, 1'b1, 8'hE7};
    tv[7] = '{16'h4017, 8'h00, 1'b1, 8'hE0};
    tv[8] = '{16'h4017, 8'h12, 1'b0, 8'h12};
    tv[9] = '{16'h4000, 8'h00, 1'b1, 8'h12};

    nrst = 1'b0;
    bus(16'h0000, 8'h00, 1'b1);
    ppu_ack = 1'b0;
    ppu_rdata = 8'h00;
    cart_ack = 1'b0;
    cart_rdata = 8'h00;
    joy1_buttons = 8'h00;
    joy2_buttons = 8'h00;
    #12;
    chk("rst_data", {8'h0, data_output}, 16'h0000);
    chk("rst_rdy", {15'h0, rdy_output}, 16'h0001);
    chk("rst_reqs", {14'h0, ppu_req, cart_req}, 16'h0000);
    chk("rst_nrw", {14'h0, ppu_nrw, cart_nrw}, 16'h0003);
    chk("rst_cart_addr", cart_addr, 16'h0000);
    chk("rst_ppu_f", {5'h0, ppu_addr, ppu_wdata}, 16'h0000);
    nrst = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      bus(tv[i].a, tv[i].d, tv[i].nrw);
      step();
      chk($sformatf("vec%0d_data", i), {8'h0, data_output},
          {8'h0, tv[i].exp});
      chk($sformatf("vec%0d_rdy", i), {15'h0, rdy_output}, 16'h0001);
    end

    // controller 1 latch then serial read
    joy1_buttons = 8'h81;
    bus(16'h4016, 8'h01, 1'b0);
    step();
    bus(16'h4016, 8'h00, 1'b0);
    step();
    joy1_buttons = 8'h00;
    begin
      logic [8:0] seq;
      seq = 9'b110000001;
      for (int i = 0; i < 9; i++) begin
        bus(16'h4016, 8'h00, 1'b1);
        step();
        chk($sformatf("joy_rd%0d", i), {11'h0, data_output[4:0]},
            {15'h0, seq[i]});
      end
    end

    // strobe high: live bit0, no shift
    bus(16'h4016, 8'h01, 1'b0);
    step();
    joy1_buttons = 8'hFE;
    bus(16'h4016, 8'h00, 1'b1);
    step();
    chk("joy_live0", {15'h0, data_output[0]}, 16'h0000);
    joy1_buttons = 8'h01;
    step();
    chk("joy_live1", {15'h0, data_output[0]}, 16'h0001);
    bus(16'h4016, 8'h00, 1'b0);
    step();

    // PPU read, ack after 3 cycles
    bus(16'h3FFA, 8'h00, 1'b1);
    step();
    chk("ppu_req", {15'h0, ppu_req}, 16'h0001);
    chk("ppu_rdy", {15'h0, rdy_output}, 16'h0000);
    chk("ppu_addr", {13'h0, ppu_addr}, 16'h0002);
    bus(16'h0000, 8'h00, 1'b0);
    step();
    step();
    chk("ppu_hold", {14'h0, ppu_req, rdy_output}, 16'h0002);
    ppu_ack = 1'b1;
    ppu_rdata = 8'h5C;
    step();
    chk("ppu_rd_data", {8'h0, data_output}, 16'h005C);
    chk("ppu_done", {14'h0, ppu_req, rdy_output}, 16'h0001);
    // ack while idle is ignored
    bus(16'h0005, 8'h00, 1'b1);
    step();
    chk("idle_ack", {14'h0, ppu_req, rdy_output}, 16'h0001);
    chk("idle_ack_data", {8'h0, data_output}, 16'h00A5);
    ppu_ack = 1'b0;

    // PPU write, then open bus sees its data
    bus(16'h2006, 8'h3F, 1'b0);
    step();
    chk("ppu_w_f", {4'h0, ppu_nrw, ppu_addr, ppu_wdata}, 16'h063F);
    ppu_ack = 1'b1;
    bus(16'h4000, 8'h00, 1'b1);
    step();
    chk("ppu_w_done", {15'h0, rdy_output}, 16'h0001);
    ppu_ack = 1'b0;
    step();
    chk("ob_after_ppu_w", {8'h0, data_output}, 16'h003F);

    // cart with ack already high: one stall cycle
    cart_ack = 1'b1;
    cart_rdata = 8'h9D;
    bus(16'hC123, 8'h00, 1'b1);
    step();
    chk("cart_fast_req", {14'h0, cart_req, rdy_output}, 16'h0002);
    chk("cart_addr", cart_addr, 16'hC123);
    bus(16'h4000, 8'h00, 1'b1);
    step();
    chk("cart_fast_done", {14'h0, cart_req, rdy_output}, 16'h0001);
    chk("cart_fast_data", {8'h0, data_output}, 16'h009D);
    cart_ack = 1'b0;
    cart_rdata = 8'hAA;

    // cart timeout read returns open bus
    bus(16'h0010, 8'h33, 1'b0);
    step();
    bus(16'h0010, 8'h00, 1'b1);
    step();
    bus(16'h8000, 8'h00, 1'b1);
    step();
    chk("tmo_req", {14'h0, cart_req, rdy_output}, 16'h0002);
    bus(16'h0000, 8'h00, 1'b1);
    for (int i = 1; i < 16; i++) begin
      step();
      chk($sformatf("tmo_wait%0d", i), {15'h0, rdy_output}, 16'h0000);
    end
    step();
    chk("tmo_done", {14'h0, cart_req, rdy_output}, 16'h0001);
    chk("tmo_data", {8'h0, data_output}, 16'h0033);

    // open bus upper bits on pad read
    bus(16'h4005, 8'hE7, 1'b0);
    step();
    bus(16'h4017, 8'h00, 1'b1);
    step();
    chk("ob_pad_hi", {13'h0, data_output[7:5]}, 16'h0007);

    // async reset in the middle of a cart wait
    bus(16'h8000, 8'h00, 1'b1);
    step();
    chk("mid_req", {15'h0, cart_req}, 16'h0001);
    #2;
    nrst = 1'b0;
    #1;
    chk("mid_rst_req", {15'h0, cart_req}, 16'h0000);
    chk("mid_rst_rdy", {15'h0, rdy_output}, 16'h0001);
    step();
    nrst = 1'b1;
    bus(16'h0100, 8'h5A, 1'b0);
    step();
    bus(16'h0900, 8'h00, 1'b1);
    step();
    chk("post_rst_ram", {8'h0, data_output}, 16'h005A);
    chk("post_rst_rdy", {15'h0, rdy_output}, 16'h0001);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
